branch_unit: RTL and testbench

- Control-flow resolver that drives the program counter's `branchTarget`/`branchEnable` inputs.
- Each cycle it receives the decoded control opcode and operand for the instruction at `currentPointer`, which is the PC's `instructionPointer`.
- It resolves JMP/JZ/JNZ/CALL/RET against a zero flag and an internal return-address stack.
- Decisions are registered, giving an architectural one-instruction branch delay slot.

---
 rtl/branch_unit.sv | 134 +++++++++++++
 tb/tb_branch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_unit                                                                |
// | Resolves JMP/JZ/JNZ/CALL/RET into a registered PC load with a delay slot. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             instrValid,
    input  logic [2:0]                       opcode,
    input  logic [ADDR_WIDTH-1:0]            operand,
    input  logic [ADDR_WIDTH-1:0]            currentPointer,
    input  logic                             aluZero,
    input  logic                             aluZeroValid,
    output logic [ADDR_WIDTH-1:0]            branchTarget,
    output logic                             branchEnable,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stackDepth,
    output logic                             stackOverflow,
    output logic                             stackUnderflow
);

    localparam int                 c_DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int                 c_IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [c_DEPTH_W-1:0] c_FULL  = c_DEPTH_W'(STACK_DEPTH);
    localparam logic [c_DEPTH_W-1:0] c_ONE   = c_DEPTH_W'(1);

    localparam logic [2:0] c_OP_JMP  = 3'b001;
    localparam logic [2:0] c_OP_JZ   = 3'b010;
    localparam logic [2:0] c_OP_JNZ  = 3'b011;
    localparam logic [2:0] c_OP_CALL = 3'b100;
    localparam logic [2:0] c_OP_RET  = 3'b101;

    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] r_tgt;
    logic                  r_en;
    logic [c_DEPTH_W-1:0]  r_depth;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_zero_flag;

    logic                  w_active;
    logic                  w_eff_zero;
    logic                  w_full;
    logic                  w_empty;
    logic [c_IDX_W-1:0]    w_top_idx;
    logic [c_IDX_W-1:0]    w_push_idx;
    logic [ADDR_WIDTH-1:0] w_ret_addr;
    logic                  w_taken;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf_set;
    logic                  w_unf_set;

    // The delay-slot instruction is squashed so a branch can never chain.
    assign w_active   = instrValid && !r_en;
    assign w_eff_zero = aluZeroValid ? aluZero : r_zero_flag;
    assign w_full     = (r_depth == c_FULL);
    assign w_empty    = (r_depth == '0);
    assign w_top_idx  = c_IDX_W'(r_depth - c_ONE);
    assign w_push_idx = c_IDX_W'(r_depth);
    assign w_ret_addr = currentPointer + ADDR_WIDTH'(2);

    always_comb begin
        w_taken   = 1'b0;
        w_target  = operand;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (w_active) begin
            case (opcode)
                c_OP_JMP:  w_taken = 1'b1;
                c_OP_JZ:   w_taken = w_eff_zero;
                c_OP_JNZ:  w_taken = !w_eff_zero;
                c_OP_CALL: begin
                    w_taken   = 1'b1;
                    w_push    = !w_full;
                    w_ovf_set = w_full;
                end
                c_OP_RET: begin
                    w_taken   = !w_empty;
                    w_pop     = !w_empty;
                    w_unf_set = w_empty;
                    w_target  = r_stack[w_top_idx];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en        <= 1'b0;
            r_tgt       <= '0;
            r_depth     <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_zero_flag <= 1'b0;
        end else begin
            r_en <= w_taken;
            if (w_taken)
                r_tgt <= w_target;
            if (aluZeroValid)
                r_zero_flag <= aluZero;
            if (w_push)
                r_depth <= r_depth + c_ONE;
            else if (w_pop)
                r_depth <= r_depth - c_ONE;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            if (w_unf_set)
                r_unf <= 1'b1;
        end
    end

    // Stack storage carries no reset; validity is tracked by r_depth alone.
    always_ff @(posedge clk) begin
        if (w_push)
            r_stack[w_push_idx] <= w_ret_addr;
    end

    assign branchEnable   = r_en;
    assign branchTarget   = r_tgt;
    assign stackDepth     = r_depth;
    assign stackOverflow  = r_ovf;
    assign stackUnderflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_unit                                                             |
// | Directed and randomized checks of branch_unit against a queue model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_unit;

    localparam int c_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       instrValid;
    logic [2:0] opcode;
    logic [7:0] operand;
    logic [7:0] currentPointer;
    logic       aluZero;
    logic       aluZeroValid;
    logic [7:0] branchTarget;
    logic       branchEnable;
    logic [2:0] stackDepth;
    logic       stackOverflow;
    logic       stackUnderflow;

    int tests = 0;
    int fails = 0;

    // Reference state: pending-load bit, held target, flag, LIFO queue, sticky flags.
    bit         m_en;
    logic [7:0] m_tgt;
    bit         m_zf;
    logic [7:0] m_stack[$];
    bit         m_ovf;
    bit         m_unf;

    branch_unit #(.STACK_DEPTH(c_DEPTH), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .instrValid(instrValid), .opcode(opcode),
        .operand(operand), .currentPointer(currentPointer), .aluZero(aluZero),
        .aluZeroValid(aluZeroValid), .branchTarget(branchTarget),
        .branchEnable(branchEnable), .stackDepth(stackDepth),
        .stackOverflow(stackOverflow), .stackUnderflow(stackUnderflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_en = 0; m_tgt = 8'h00; m_zf = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
    endtask

    task automatic model_step(input bit v, input logic [2:0] op, input logic [7:0] opd,
                              input logic [7:0] pc, input bit az, input bit azv);
        bit         ez;
        bit         tk;
        logic [7:0] t;
        logic [7:0] ra;
        ez = azv ? az : m_zf;
        tk = 0;
        t  = opd;
        ra = pc + 8'd2;
        if (v && !m_en) begin
            case (op)
                3'd1: tk = 1;
                3'd2: tk = ez;
                3'd3: tk = !ez;
                3'd4: begin
                    tk = 1;
                    if (m_stack.size() < c_DEPTH) m_stack.push_back(ra);
                    else m_ovf = 1;
                end
                3'd5: begin
                    if (m_stack.size() > 0) begin tk = 1; t = m_stack.pop_back(); end
                    else m_unf = 1;
                end
                default: ;
            endcase
        end
        if (azv) m_zf = az;
        m_en = tk;
        if (tk) m_tgt = t;
    endtask

    // Drive one cycle's inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input bit v, input logic [2:0] op, input logic [7:0] opd,
                         input logic [7:0] pc, input bit az, input bit azv);
        instrValid = v; opcode = op; operand = opd; currentPointer = pc;
        aluZero = az; aluZeroValid = azv;
        model_step(v, op, opd, pc, az, azv);
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        cycle(0, 3'd0, 8'h00, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        nop();
        nop();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            instrValid = 1'($urandom); opcode = 3'($urandom); operand = 8'($urandom);
            currentPointer = 8'($urandom); aluZero = 1'($urandom); aluZeroValid = 1'($urandom);
            @(posedge clk);
            #1;
        end
        tests++;
        if (branchEnable !== 1'b0 || branchTarget !== 8'h00 || stackDepth !== 3'd0 ||
            stackOverflow !== 1'b0 || stackUnderflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: en=%b tgt=%h depth=%0d ovf=%b unf=%b, want 0/00/0/0/0",
                     branchEnable, branchTarget, stackDepth, stackOverflow, stackUnderflow);
        end
        rst = 1'b1;
        nop();
        nop();
        tests++;
        if (branchEnable !== 1'b0 || branchTarget !== 8'h00 || stackDepth !== 3'd0) begin
            fails++;
            $display("FAIL reset_release: en=%b tgt=%h depth=%0d, want 0/00/0",
                     branchEnable, branchTarget, stackDepth);
        end
    endtask

    task automatic test_jmp();
        cycle(1, 3'd1, 8'h40, 8'h10, 0, 0);
        tests++;
        if (branchEnable !== 1'b1 || branchTarget !== 8'h40) begin
            fails++;
            $display("FAIL jmp_taken: en=%b tgt=%h, want 1/40", branchEnable, branchTarget);
        end
        cycle(1, 3'd1, 8'h90, 8'h11, 0, 0);
        tests++;
        if (branchEnable !== 1'b0 || branchTarget !== 8'h40) begin
            fails++;
            $display("FAIL jmp_delay_slot: en=%b tgt=%h, want 0/40", branchEnable, branchTarget);
        end
        nop();
        tests++;
        if (branchEnable !== 1'b0) begin
            fails++;
            $display("FAIL jmp_no_second_pulse: en=%b, want 0", branchEnable);
        end
    endtask

    task automatic test_conditional();
        cycle(0, 3'd0, 8'h00, 8'h00, 0, 1);
        cycle(1, 3'd2, 8'h33, 8'h50, 1, 1);
        tests++;
        if (branchEnable !== 1'b1 || branchTarget !== 8'h33) begin
            fails++;
            $display("FAIL jz_bypass: en=%b tgt=%h, want 1/33", branchEnable, branchTarget);
        end
        nop();
        cycle(1, 3'd3, 8'h44, 8'h34, 0, 0);
        tests++;
        if (branchEnable !== 1'b0 || branchTarget !== 8'h33) begin
            fails++;
            $display("FAIL jnz_flag_set: en=%b tgt=%h, want 0/33", branchEnable, branchTarget);
        end
        cycle(1, 3'd2, 8'h55, 8'h35, 0, 0);
        tests++;
        if (branchEnable !== 1'b1 || branchTarget !== 8'h55) begin
            fails++;
            $display("FAIL jz_flag_held: en=%b tgt=%h, want 1/55", branchEnable, branchTarget);
        end
        nop();
    endtask

    task automatic test_call_ret();
        do_reset();
        cycle(1, 3'd4, 8'h80, 8'h20, 0, 0);
        tests++;
        if (branchEnable !== 1'b1 || branchTarget !== 8'h80 || stackDepth !== 3'd1) begin
            fails++;
            $display("FAIL call: en=%b tgt=%h depth=%0d, want 1/80/1",
                     branchEnable, branchTarget, stackDepth);
        end
        nop();
        cycle(1, 3'd5, 8'h00, 8'h80, 0, 0);
        tests++;
        if (branchEnable !== 1'b1 || branchTarget !== 8'h22 || stackDepth !== 3'd0) begin
            fails++;
            $display("FAIL ret: en=%b tgt=%h depth=%0d, want 1/22/0",
                     branchEnable, branchTarget, stackDepth);
        end
        nop();
        cycle(1, 3'd4, 8'h60, 8'hFF, 0, 0);
        nop();
        cycle(1, 3'd5, 8'h00, 8'h60, 0, 0);
        tests++;
        if (branchEnable !== 1'b1 || branchTarget !== 8'h01) begin
            fails++;
            $display("FAIL call_wrap: en=%b tgt=%h, want 1/01", branchEnable, branchTarget);
        end
        nop();
    endtask

    task automatic test_overflow_underflow();
        logic [7:0] exp_ret[4];
        exp_ret = '{8'h32, 8'h22, 8'h12, 8'h02};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 3'd4, 8'hA0 + 8'(i), 8'(i * 16), 0, 0);
            tests++;
            if (branchEnable !== 1'b1 || branchTarget !== 8'hA0 + 8'(i) ||
                stackOverflow !== (i == 4)) begin
                fails++;
                $display("FAIL call_%0d: en=%b tgt=%h ovf=%b, want 1/%h/%b", i,
                         branchEnable, branchTarget, stackOverflow, 8'hA0 + 8'(i), (i == 4));
            end
            nop();
        end
        tests++;
        if (stackDepth !== 3'd4) begin
            fails++;
            $display("FAIL depth_full: depth=%0d, want 4", stackDepth);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 3'd5, 8'h00, 8'h70, 0, 0);
            tests++;
            if (branchEnable !== 1'b1 || branchTarget !== exp_ret[i]) begin
                fails++;
                $display("FAIL ret_%0d: en=%b tgt=%h, want 1/%h", i,
                         branchEnable, branchTarget, exp_ret[i]);
            end
            nop();
        end
        cycle(1, 3'd5, 8'h00, 8'h70, 0, 0);
        tests++;
        if (branchEnable !== 1'b0 || stackUnderflow !== 1'b1 || stackDepth !== 3'd0 ||
            stackOverflow !== 1'b1) begin
            fails++;
            $display("FAIL underflow: en=%b unf=%b depth=%0d ovf=%b, want 0/1/0/1",
                     branchEnable, stackUnderflow, stackDepth, stackOverflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1, 3'd4, 8'hC0, 8'h08, 0, 0);
        instrValid = 1'b0;
        opcode     = 3'd0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (branchEnable !== 1'b0 || stackDepth !== 3'd0 || branchTarget !== 8'h00) begin
            fails++;
            $display("FAIL async_reset: en=%b depth=%0d tgt=%h, want 0/0/00",
                     branchEnable, stackDepth, branchTarget);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nop();
            tests++;
            if (branchEnable !== 1'b0) begin
                fails++;
                $display("FAIL async_reset_no_branch: cycle %0d en=%b, want 0", i, branchEnable);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 9) < 4) ? (($urandom_range(0, 1) == 1) ? 3'd4 : 3'd5)
                                             : 3'($urandom);
            cycle(($urandom_range(0, 3) != 0), op, 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom));
            tests++;
            if (branchEnable !== m_en || branchTarget !== m_tgt ||
                stackDepth !== 3'(m_stack.size()) ||
                stackOverflow !== m_ovf || stackUnderflow !== m_unf) begin
                fails++;
                $display("FAIL random_%0d: en=%b tgt=%h depth=%0d ovf=%b unf=%b, want %b/%h/%0d/%b/%b",
                         i, branchEnable, branchTarget, stackDepth, stackOverflow, stackUnderflow,
                         m_en, m_tgt, m_stack.size(), m_ovf, m_unf);
            end
            if (i == 300) do_reset();
        end
    endtask

    initial begin
        rst = 1'b0;
        instrValid = 0; opcode = 0; operand = 0; currentPointer = 0;
        aluZero = 0; aluZeroValid = 0;
        model_reset();
        test_reset();
        test_jmp();
        test_conditional();
        test_call_ret();
        test_overflow_underflow();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
